// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the two requester channels, the result channel and the delivered
//   result count that connect the issue logic to the shared ALU.
//   master : the requester/consumer side (drives requests and rsp_ready)
//   slave  : the shared ALU side (drives readies, result and op_count)
//   Signals per requester N in {0,1}: reqN_valid, reqN_ready, reqN_sel[2:0],
//   reqN_a/reqN_b[DATA_WIDTH-1:0].
//   Result: rsp_valid, rsp_ready, rsp_id, rsp_data[DATA_WIDTH-1:0], rsp_zero,
//   op_count[CNT_WIDTH-1:0].
interface alu_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) ();
   logic                  req0_valid;
   logic                  req0_ready;
   logic [2:0]            req0_sel;
   logic [DATA_WIDTH-1:0] req0_a;
   logic [DATA_WIDTH-1:0] req0_b;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [2:0]            req1_sel;
   logic [DATA_WIDTH-1:0] req1_a;
   logic [DATA_WIDTH-1:0] req1_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_id;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_zero;
   logic [CNT_WIDTH-1:0]  op_count;

   modport master (
      output req0_valid, req0_sel, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_sel, req1_a, req1_b,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_zero, op_count,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_sel, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_sel, req1_a, req1_b,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_zero, op_count,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one ALU between two requesters with a round-robin arbiter. The
//   granted operation is computed in a single pass and captured in a
//   one-entry result register tagged with the requester id. A wrapping
//   counter tracks delivered results.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous reset, active low
//     bus   : alu_arbiter_if.slave (request channels, result channel, op_count)
module alu_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic         clk,
   input logic         rst_n,
   alu_arbiter_if.slave bus
);

   function automatic logic [DATA_WIDTH-1:0] alu_calc(
      input logic [2:0]            sel,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      case (sel)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b100:  r = a - b;
         3'b101:  r = a * b;
         3'b110:  r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
         default: r = '0;
      endcase
      return r;
   endfunction

   logic                  vld_p1;
   logic                  id_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  zero_p1;
   logic [CNT_WIDTH-1:0]  count;
   logic                  last_grant;

   logic                  can_issue;
   logic                  grant0;
   logic                  grant1;
   logic                  xfer;
   logic                  deliver;
   logic [2:0]            sel_p0;
   logic [DATA_WIDTH-1:0] a_p0;
   logic [DATA_WIDTH-1:0] b_p0;
   logic [DATA_WIDTH-1:0] result_p0;

   // ---- stage p0: arbitration and ALU evaluation of the granted operands ----
   assign can_issue = !vld_p1 || bus.rsp_ready;
   // With both valid, the requester that was not served last wins; readies are
   // held low during reset so nothing is accepted then.
   assign grant0 = rst_n && can_issue && bus.req0_valid && (!bus.req1_valid || last_grant);
   assign grant1 = rst_n && can_issue && bus.req1_valid && (!bus.req0_valid || !last_grant);
   assign xfer    = grant0 || grant1;
   assign deliver = vld_p1 && bus.rsp_ready;

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   assign sel_p0    = grant1 ? bus.req1_sel : bus.req0_sel;
   assign a_p0      = grant1 ? bus.req1_a   : bus.req0_a;
   assign b_p0      = grant1 ? bus.req1_b   : bus.req0_b;
   assign result_p0 = alu_calc(sel_p0, a_p0, b_p0);

   // ---- stage p1: one-entry result register and delivery counter ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         id_p1      <= 1'b0;
         data_p1    <= '0;
         zero_p1    <= 1'b1;
         count      <= '0;
         last_grant <= 1'b1;
      end else begin
         if (deliver) begin
            count <= count + 1'b1;
         end
         // A transfer in the same cycle as a delivery overwrites the entry,
         // giving back-to-back results without a bubble.
         if (xfer) begin
            vld_p1     <= 1'b1;
            id_p1      <= grant1;
            data_p1    <= result_p0;
            zero_p1    <= (result_p0 == '0);
            last_grant <= grant1;
         end else if (deliver) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_id    = id_p1;
   assign bus.rsp_data  = data_p1;
   assign bus.rsp_zero  = zero_p1;
   assign bus.op_count  = count;

endmodule
